// File: rtl/sqrt_pkg.sv
// Shared types and constants for the BCD square-root engine.
package sqrt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONVERT,
        ROOT,
        DABBLE,
        FINISH
    } state_t;

    localparam int unsigned ACC_W         = 40;
    localparam int unsigned ROOT_W        = 20;
    localparam int unsigned BCD_DIGITS    = 6;
    localparam int unsigned CONVERT_STEPS = 12;
    localparam int unsigned ROOT_STEPS    = 20;
    localparam int unsigned DABBLE_STEPS  = 20;

    localparam logic [4*BCD_DIGITS-1:0] ERR_BCD = 24'hEEEEEE;

endpackage

// File: rtl/bcd_sqrt_unit_if.sv
// Start/done handshake and operand/result bus of the square-root engine.
interface bcd_sqrt_unit_if;

    logic        start;
    logic [23:0] num_bcd;
    logic        busy;
    logic        done;
    logic [23:0] root_bcd;
    logic        err;

    modport master (
        output start,
        output num_bcd,
        input  busy,
        input  done,
        input  root_bcd,
        input  err
    );

    modport slave (
        input  start,
        input  num_bcd,
        output busy,
        output done,
        output root_bcd,
        output err
    );

endinterface

// File: rtl/bcd_dabble.sv
// One combinational double-dabble step: add 3 to BCD digits >= 5, then shift {bcd, bin} left.
module bcd_dabble
    import sqrt_pkg::*;
(
    input  logic [4*BCD_DIGITS-1:0] bcd,
    input  logic [ROOT_W-1:0]       bin,
    output logic [4*BCD_DIGITS-1:0] bcd_next,
    output logic [ROOT_W-1:0]       bin_next
);

    logic [4*BCD_DIGITS-1:0] adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        bcd_next = {adj[4*BCD_DIGITS-2:0], bin[ROOT_W-1]};
        bin_next = {bin[ROOT_W-2:0], 1'b0};
    end

endmodule

// File: rtl/bcd_sqrt_unit.sv
// Sequential packed-BCD square root: floor(sqrt(N) * 1000) as 3.3 BCD digits.
module bcd_sqrt_unit
    import sqrt_pkg::*;
#(
    parameter int unsigned FRAC_DIGITS = 3,
    parameter int unsigned ROOT_W      = 20
) (
    input  logic                   clock,
    input  logic                   reset,
    bcd_sqrt_unit_if.slave         bus
);

    localparam int unsigned REM_W       = ROOT_W + 3;
    localparam int unsigned BCD_W       = 4 * BCD_DIGITS;
    localparam int unsigned ZERO_DIGITS = 2 * FRAC_DIGITS;

    localparam logic [5:0] CONVERT_LAST = 6'(CONVERT_STEPS - 1);
    localparam logic [5:0] ROOT_LAST    = 6'(ROOT_STEPS - 1);
    localparam logic [5:0] DABBLE_LAST  = 6'(DABBLE_STEPS - 1);
    localparam logic [5:0] DIGIT_STEPS  = 6'(CONVERT_STEPS - ZERO_DIGITS);

    state_t             state_q, state_d;
    logic [5:0]         cnt_q;
    logic [BCD_W-1:0]   num_q;
    logic [ACC_W-1:0]   acc_q;
    logic [REM_W-1:0]   rem_q;
    logic [ROOT_W-1:0]  root_q;
    logic [BCD_W-1:0]   bcd_q;
    logic               invalid_q;
    logic               done_q;
    logic [BCD_W-1:0]   root_bcd_q;
    logic               err_q;
    logic               busy;

    logic [3:0]         digit;
    logic [ACC_W-1:0]   acc_next;
    logic [REM_W+1:0]   rem_shift;
    logic [REM_W+1:0]   trial;
    logic               fits;
    logic [BCD_W-1:0]   bcd_next;
    logic [ROOT_W-1:0]  bin_next;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = CONVERT;
            CONVERT: if (cnt_q == CONVERT_LAST) state_d = ROOT;
            ROOT:    if (cnt_q == ROOT_LAST) state_d = DABBLE;
            DABBLE:  if (cnt_q == DABBLE_LAST) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_q != IDLE);
    end

    assign bus.busy     = busy;
    assign bus.done     = done_q;
    assign bus.root_bcd = root_bcd_q;
    assign bus.err      = err_q;

    // Operand digits MS first, then zero digits that scale N by 10^(2*FRAC_DIGITS)
    always_comb begin
        digit = 4'd0;
        if (cnt_q < DIGIT_STEPS) begin
            for (int i = 0; i < int'(BCD_DIGITS); i++) begin
                if (cnt_q == 6'(int'(BCD_DIGITS) - 1 - i)) begin
                    digit = num_q[4*i +: 4];
                end
            end
        end
        acc_next  = (acc_q << 3) + (acc_q << 1) + ACC_W'(digit);
        rem_shift = {rem_q, acc_q[ACC_W-1 -: 2]};
        trial     = (REM_W+2)'({root_q, 2'b01});
        fits      = (rem_shift >= trial);
    end

    bcd_dabble u_dabble (
        .bcd      (bcd_q),
        .bin      (root_q),
        .bcd_next (bcd_next),
        .bin_next (bin_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q      <= '0;
            num_q      <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            root_q     <= '0;
            bcd_q      <= '0;
            invalid_q  <= 1'b0;
            done_q     <= 1'b0;
            root_bcd_q <= '0;
            err_q      <= 1'b0;
        end else begin
            cnt_q  <= (state_d != state_q) ? 6'd0 : cnt_q + 6'd1;
            done_q <= (state_q == FINISH);
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        num_q     <= bus.num_bcd;
                        acc_q     <= '0;
                        invalid_q <= 1'b0;
                    end
                end
                CONVERT: begin
                    acc_q <= acc_next;
                    if (digit > 4'd9) invalid_q <= 1'b1;
                    if (cnt_q == CONVERT_LAST) begin
                        rem_q  <= '0;
                        root_q <= '0;
                    end
                end
                ROOT: begin
                    acc_q  <= acc_q << 2;
                    rem_q  <= fits ? REM_W'(rem_shift - trial) : REM_W'(rem_shift);
                    root_q <= {root_q[ROOT_W-2:0], fits};
                    if (cnt_q == ROOT_LAST) bcd_q <= '0;
                end
                DABBLE: begin
                    bcd_q  <= bcd_next;
                    root_q <= bin_next;
                end
                FINISH: begin
                    root_bcd_q <= invalid_q ? ERR_BCD : bcd_q;
                    err_q      <= invalid_q;
                end
                default: ;
            endcase
        end
    end

endmodule
